// File: rtl/lc3b_wb_buffer_pkg.sv
// Shared types and line-geometry constants for the LC-3b write-back buffer.
// The L1/L2 constants let either cache side pick its parameters by name.
package lc3b_wb_buffer_pkg;

   typedef enum logic [1:0] {
      WB_IDLE  = 2'd0,
      WB_WRITE = 2'd1,
      WB_GAP   = 2'd2
   } lc3b_wbuf_state;

   localparam int LC3B_L1_LINE_W    = 128;
   localparam int LC3B_L2_LINE_W    = 256;
   localparam int LC3B_OFFSET_W_L1  = 4;
   localparam int LC3B_OFFSET_W_L2  = 5;

endpackage

// File: rtl/lc3b_wbuf_match.sv
// DEPTH-way tag comparator that reports the youngest valid match, scanning
// from head toward tail; the head slot can be masked while it is in flight.
module lc3b_wbuf_match #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 12,
   parameter int PTR_W = 2
) (
   input  logic [DEPTH-1:0]            valid_i,
   input  logic [DEPTH-1:0][TAG_W-1:0] tags_i,
   input  logic [TAG_W-1:0]            tag_i,
   input  logic [PTR_W-1:0]            head_i,
   input  logic                        excl_head_i,
   output logic                        hit_o,
   output logic [PTR_W-1:0]            idx_o
);

   always_comb begin
      hit_o = 1'b0;
      idx_o = '0;
      // Later iterations are younger entries, so the last hit wins.
      for (int k = 0; k < DEPTH; k++) begin
         int p;
         logic [PTR_W-1:0] slot;
         p = int'(head_i) + k;
         if (p >= DEPTH) p = p - DEPTH;
         slot = PTR_W'(p);
         if (valid_i[slot] && (tags_i[slot] == tag_i) && !(excl_head_i && (k == 0))) begin
            hit_o = 1'b1;
            idx_o = slot;
         end
      end
   end

endmodule

// File: rtl/lc3b_wb_buffer.sv
// Write-back (victim) buffer: one-cycle eviction accept with coalescing,
// FIFO drain over a pmem write handshake, and lookup of buffered lines.
module lc3b_wb_buffer
   import lc3b_wb_buffer_pkg::*;
#(
   parameter int LINE_W   = 128,
   parameter int ADDR_W   = 16,
   parameter int OFFSET_W = 4,
   parameter int DEPTH    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       wb_valid,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [LINE_W-1:0]          wb_line,
   output logic                       wb_ready,
   input  logic [ADDR_W-1:0]          lk_addr,
   output logic                       lk_hit,
   output logic [LINE_W-1:0]          lk_line,
   output logic [ADDR_W-1:0]          pmem_address,
   output logic [LINE_W-1:0]          pmem_wdata,
   output logic                       pmem_write,
   input  logic                       pmem_resp,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full,
   output lc3b_wbuf_state             wb_state
);

   localparam int TAG_W = ADDR_W - OFFSET_W;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DEPTH-1:0]            valid_q;
   logic [DEPTH-1:0][TAG_W-1:0] tag_q;
   logic [LINE_W-1:0]           data_q [DEPTH];
   logic [PTR_W-1:0]            head_q, tail_q;
   logic [CNT_W-1:0]            count_q;
   lc3b_wbuf_state              state_q;
   logic                        pmem_write_q;

   logic [TAG_W-1:0] wb_tag, lk_tag;
   logic             cm_hit, lk_match;
   logic [PTR_W-1:0] cm_idx, lk_idx;
   logic             push, alloc, pop;
   logic             unused_offsets;

   assign wb_tag = wb_addr[ADDR_W-1:OFFSET_W];
   assign lk_tag = lk_addr[ADDR_W-1:OFFSET_W];
   assign unused_offsets = ^{wb_addr[OFFSET_W-1:0], lk_addr[OFFSET_W-1:0]};

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   // Once the head is handed to pmem its data must stay frozen, so it only
   // takes part in coalescing while the drain FSM is idle.
   lc3b_wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_coalesce (
      .valid_i     (valid_q),
      .tags_i      (tag_q),
      .tag_i       (wb_tag),
      .head_i      (head_q),
      .excl_head_i (state_q != WB_IDLE),
      .hit_o       (cm_hit),
      .idx_o       (cm_idx)
   );

   lc3b_wbuf_match #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PTR_W(PTR_W)) u_lookup (
      .valid_i     (valid_q),
      .tags_i      (tag_q),
      .tag_i       (lk_tag),
      .head_i      (head_q),
      .excl_head_i (1'b0),
      .hit_o       (lk_match),
      .idx_o       (lk_idx)
   );

   // Handshakes: an eviction transfers on a rising edge where wb_valid &&
   // wb_ready; a pmem write completes on an edge where pmem_write && pmem_resp.
   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign wb_ready = !full || cm_hit;
   assign push     = wb_valid && wb_ready;
   assign alloc    = push && !cm_hit;
   assign pop      = (state_q == WB_WRITE) && pmem_resp;

   assign count        = count_q;
   assign wb_state     = state_q;
   assign pmem_write   = pmem_write_q;
   assign pmem_address = {tag_q[head_q], {OFFSET_W{1'b0}}};
   assign pmem_wdata   = data_q[head_q];
   assign lk_hit       = lk_match;
   assign lk_line      = lk_match ? data_q[lk_idx] : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q      <= '0;
         tag_q        <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         state_q      <= WB_IDLE;
         pmem_write_q <= 1'b0;
      end else begin
         if (pop) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= ptr_inc(head_q);
         end
         if (push) begin
            if (cm_hit) begin
               data_q[cm_idx] <= wb_line;
            end else begin
               valid_q[tail_q] <= 1'b1;
               tag_q[tail_q]   <= wb_tag;
               data_q[tail_q]  <= wb_line;
               tail_q          <= ptr_inc(tail_q);
            end
         end

         case ({alloc, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase

         case (state_q)
            WB_IDLE: begin
               if (!empty) begin
                  state_q      <= WB_WRITE;
                  pmem_write_q <= 1'b1;
               end
            end
            WB_WRITE: begin
               if (pmem_resp) begin
                  state_q      <= WB_GAP;
                  pmem_write_q <= 1'b0;
               end
            end
            default: begin
               state_q      <= WB_IDLE;
               pmem_write_q <= 1'b0;
            end
         endcase
      end
   end

endmodule
